// File: rtl/video_timing_pkg.sv
// Shared constants, decoded-output bundle and flip helper for the video timing chain.
// TankBatt default timing lives here so the top and any wrappers agree on one set of numbers.
package video_timing_pkg;

    localparam int CNT_W = 9;

    localparam int DEF_H_TOTAL      = 384;
    localparam int DEF_H_ACTIVE     = 256;
    localparam int DEF_H_SYNC_START = 288;
    localparam int DEF_H_SYNC_END   = 320;
    localparam int DEF_V_TOTAL      = 264;
    localparam int DEF_V_ACTIVE     = 224;
    localparam int DEF_V_SYNC_START = 240;
    localparam int DEF_V_SYNC_END   = 244;

    typedef struct packed {
        logic n_hsync;
        logic n_vsync;
        logic hblank;
        logic vblank;
        logic frame_end;
    } sync_t;

    localparam sync_t SYNC_RESET = '{
        n_hsync:   1'b1,
        n_vsync:   1'b1,
        hblank:    1'b0,
        vblank:    1'b0,
        frame_end: 1'b0
    };

    // Cocktail flip mirrors the low eight bits only; bit 8 keeps the blanking half intact.
    function automatic logic [CNT_W-1:0] flip_cnt(input logic [CNT_W-1:0] c);
        return {c[CNT_W-1], ~c[CNT_W-2:0]};
    endfunction

endpackage

// File: rtl/video_timing_mod_counter.sv
// Modulo-N counter with a registered terminal-count flag (last is high while q == N-1).
// Advances on en; wraps from N-1 to 0.
module mod_counter #(
    parameter int N = 384,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         n_clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         last
);

    localparam logic [W-1:0] LAST_VAL = W'(N - 1);

    logic [W-1:0] q_q, q_d;
    logic         last_q, last_d;

    if (N < 2 || N > (1 << W)) begin : g_bad_n
        $error("mod_counter: N=%0d does not fit 2..2**W", N);
    end

    // NOTE: every always_comb output gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = last_q ? '0 : q_q + W'(1);
        end
        last_d = (q_d == LAST_VAL);
    end

    // NOTE: state updates use <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (!n_clr) begin
            q_q    <= '0;
            last_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            last_q <= last_d;
        end
    end

    assign q    = q_q;
    assign last = last_q;

endmodule

// File: rtl/video_timing.sv
// Horizontal/vertical timing chain: registered counters, active-low syncs, blanks and end strobes.
// Optional cocktail flip of the reported counters is enabled with VIDEO_TIMING_FLIP_EN.
module video_timing
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_END   = DEF_H_SYNC_END,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_END   = DEF_V_SYNC_END
) (
    input  logic             clk,
    input  logic             n_clr,
    input  logic             cen,
`ifdef VIDEO_TIMING_FLIP_EN
    input  logic             flip,
`endif
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             n_hsync,
    output logic             n_vsync,
    output logic             hblank,
    output logic             vblank,
    output logic             line_end,
    output logic             frame_end
);

    if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END &&
          H_SYNC_END <= H_TOTAL && H_TOTAL <= (1 << CNT_W))) begin : g_bad_h
        $error("video_timing: illegal horizontal timing parameters");
    end
    if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END &&
          V_SYNC_END <= V_TOTAL && V_TOTAL <= (1 << CNT_W))) begin : g_bad_v
        $error("video_timing: illegal vertical timing parameters");
    end

    logic [CNT_W-1:0] h_q, v_q;
    logic             h_last, v_last;
    logic             h_wrap, f_wrap;
    logic [CNT_W-1:0] h_nxt, v_nxt;
    sync_t            dec_q, dec_d;

    assign h_wrap = cen & h_last;
    assign f_wrap = h_wrap & v_last;

    mod_counter #(.N(H_TOTAL), .W(CNT_W)) u_hcnt (
        .clk   (clk),
        .n_clr (n_clr),
        .en    (cen),
        .q     (h_q),
        .last  (h_last)
    );

    mod_counter #(.N(V_TOTAL), .W(CNT_W)) u_vcnt (
        .clk   (clk),
        .n_clr (n_clr),
        .en    (h_wrap),
        .q     (v_q),
        .last  (v_last)
    );

    // Decoding the post-edge counter values keeps the registered syncs aligned with hcnt/vcnt.
    always_comb begin
        h_nxt = h_q;
        v_nxt = v_q;
        if (cen) begin
            h_nxt = h_last ? '0 : h_q + CNT_W'(1);
        end
        if (h_wrap) begin
            v_nxt = v_last ? '0 : v_q + CNT_W'(1);
        end

        dec_d           = dec_q;
        dec_d.n_hsync   = !(int'(h_nxt) >= H_SYNC_START && int'(h_nxt) < H_SYNC_END);
        dec_d.n_vsync   = !(int'(v_nxt) >= V_SYNC_START && int'(v_nxt) < V_SYNC_END);
        dec_d.hblank    = int'(h_nxt) >= H_ACTIVE;
        dec_d.vblank    = int'(v_nxt) >= V_ACTIVE;
        dec_d.frame_end = int'(h_nxt) == H_TOTAL - 1 && int'(v_nxt) == V_TOTAL - 1;
    end

    always_ff @(posedge clk) begin
        if (!n_clr) begin
            dec_q <= SYNC_RESET;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign n_hsync   = dec_q.n_hsync;
    assign n_vsync   = dec_q.n_vsync;
    assign hblank    = dec_q.hblank;
    assign vblank    = dec_q.vblank;
    assign frame_end = dec_q.frame_end;
    assign line_end  = h_last;

`ifdef VIDEO_TIMING_FLIP_EN
    logic             flip_q, flip_d;
    logic [CNT_W-1:0] hcnt_q, vcnt_q;

    // A flip request only lands on the frame wrap so a frame is never drawn half-mirrored.
    assign flip_d = f_wrap ? flip : flip_q;

    always_ff @(posedge clk) begin
        if (!n_clr) begin
            flip_q <= 1'b0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            flip_q <= flip_d;
            hcnt_q <= flip_d ? flip_cnt(h_nxt) : h_nxt;
            vcnt_q <= flip_d ? flip_cnt(v_nxt) : v_nxt;
        end
    end

    assign hcnt = hcnt_q;
    assign vcnt = vcnt_q;
`else
    assign hcnt = h_q;
    assign vcnt = v_q;
`endif

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing: default-timing instance plus a tiny-timing instance for frame wraps.
// Behavioural model tracks a linear cen-edge position per instance and derives every output from it.
module tb_video_timing;

    localparam int DH_T = 384, DH_A = 256, DH_SS = 288, DH_SE = 320;
    localparam int DV_T = 264, DV_A = 224, DV_SS = 240, DV_SE = 244;
    localparam int SH_T = 10, SH_A = 6, SH_SS = 7, SH_SE = 9;
    localparam int SV_T = 6, SV_A = 3, SV_SS = 4, SV_SE = 5;

    logic clk = 1'b0;
    logic n_clr, cen, flip;

    logic [8:0] d_hcnt, d_vcnt, s_hcnt, s_vcnt;
    logic d_n_hsync, d_n_vsync, d_hblank, d_vblank, d_line_end, d_frame_end;
    logic s_n_hsync, s_n_vsync, s_hblank, s_vblank, s_line_end, s_frame_end;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    video_timing u_dut_d (
        .clk       (clk),
        .n_clr     (n_clr),
        .cen       (cen),
`ifdef VIDEO_TIMING_FLIP_EN
        .flip      (flip),
`endif
        .hcnt      (d_hcnt),
        .vcnt      (d_vcnt),
        .n_hsync   (d_n_hsync),
        .n_vsync   (d_n_vsync),
        .hblank    (d_hblank),
        .vblank    (d_vblank),
        .line_end  (d_line_end),
        .frame_end (d_frame_end)
    );

    video_timing #(
        .H_TOTAL(SH_T), .H_ACTIVE(SH_A), .H_SYNC_START(SH_SS), .H_SYNC_END(SH_SE),
        .V_TOTAL(SV_T), .V_ACTIVE(SV_A), .V_SYNC_START(SV_SS), .V_SYNC_END(SV_SE)
    ) u_dut_s (
        .clk       (clk),
        .n_clr     (n_clr),
        .cen       (cen),
`ifdef VIDEO_TIMING_FLIP_EN
        .flip      (flip),
`endif
        .hcnt      (s_hcnt),
        .vcnt      (s_vcnt),
        .n_hsync   (s_n_hsync),
        .n_vsync   (s_n_vsync),
        .hblank    (s_hblank),
        .vblank    (s_vblank),
        .line_end  (s_line_end),
        .frame_end (s_frame_end)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [8:0] hcnt;
        logic [8:0] vcnt;
        logic n_hsync, n_vsync, hblank, vblank, line_end, frame_end;
    } exp_t;

    function automatic exp_t model_out(input int pos, input int ht, input int ha, input int hss,
                                       input int hse, input int vt, input int va, input int vss,
                                       input int vse, input bit fl);
        exp_t e;
        int h, v;
        h = pos % ht;
        v = pos / ht;
        e.hcnt      = 9'(fl ? (h ^ 255) : h);
        e.vcnt      = 9'(fl ? (v ^ 255) : v);
        e.n_hsync   = !(h >= hss && h < hse);
        e.n_vsync   = !(v >= vss && v < vse);
        e.hblank    = h >= ha;
        e.vblank    = v >= va;
        e.line_end  = h == ht - 1;
        e.frame_end = pos == ht * vt - 1;
        return e;
    endfunction

    int pos_d = 0, pos_s = 0;
    bit fl_d = 0, fl_s = 0;
    bit model_ok = 0;

    always @(posedge clk) begin
        if (!n_clr) begin
            pos_d = 0;
            pos_s = 0;
            fl_d = 0;
            fl_s = 0;
            model_ok = 1;
        end else if (cen) begin
`ifdef VIDEO_TIMING_FLIP_EN
            if (pos_d == DH_T * DV_T - 1) fl_d = flip;
            if (pos_s == SH_T * SV_T - 1) fl_s = flip;
`endif
            pos_d = (pos_d + 1) % (DH_T * DV_T);
            pos_s = (pos_s + 1) % (SH_T * SV_T);
        end
    end

    task automatic cmp_inst(input string tag, input exp_t e, input logic [8:0] hc, input logic [8:0] vc,
                            input logic hs, input logic vs, input logic hb, input logic vb,
                            input logic le, input logic fe);
        check({tag, ".hcnt"}, 32'(hc), 32'(e.hcnt));
        check({tag, ".vcnt"}, 32'(vc), 32'(e.vcnt));
        check({tag, ".n_hsync"}, 32'(hs), 32'(e.n_hsync));
        check({tag, ".n_vsync"}, 32'(vs), 32'(e.n_vsync));
        check({tag, ".hblank"}, 32'(hb), 32'(e.hblank));
        check({tag, ".vblank"}, 32'(vb), 32'(e.vblank));
        check({tag, ".line_end"}, 32'(le), 32'(e.line_end));
        check({tag, ".frame_end"}, 32'(fe), 32'(e.frame_end));
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            cmp_inst("model_d", model_out(pos_d, DH_T, DH_A, DH_SS, DH_SE, DV_T, DV_A, DV_SS, DV_SE, fl_d),
                     d_hcnt, d_vcnt, d_n_hsync, d_n_vsync, d_hblank, d_vblank, d_line_end, d_frame_end);
            cmp_inst("model_s", model_out(pos_s, SH_T, SH_A, SH_SS, SH_SE, SV_T, SV_A, SV_SS, SV_SE, fl_s),
                     s_hcnt, s_vcnt, s_n_hsync, s_n_vsync, s_hblank, s_vblank, s_line_end, s_frame_end);
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input logic c, input logic r);
        cen = c;
        n_clr = r;
        @(posedge clk);
        #2;
    endtask

    task automatic run_cen(input int n);
        for (int i = 0; i < n; i++) apply(1'b1, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".hcnt"}, 32'(d_hcnt), 0);
        check({tag, ".vcnt"}, 32'(d_vcnt), 0);
        check({tag, ".n_hsync"}, 32'(d_n_hsync), 1);
        check({tag, ".n_vsync"}, 32'(d_n_vsync), 1);
        check({tag, ".hblank"}, 32'(d_hblank), 0);
        check({tag, ".vblank"}, 32'(d_vblank), 0);
        check({tag, ".line_end"}, 32'(d_line_end), 0);
        check({tag, ".frame_end"}, 32'(d_frame_end), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc, le;
        logic ph;
        n_clr = 1'b0;
        cen = 1'b1;
        flip = 1'b0;
        #2;

        // Reset held for three edges with cen high.
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0);
        check_reset_values("reset");

        // Line run at full rate.
        run_cen(255);
        check("h255.hcnt", 32'(d_hcnt), 255);
        check("h255.hblank", 32'(d_hblank), 0);
        run_cen(1);
        check("h256.hcnt", 32'(d_hcnt), 256);
        check("h256.hblank", 32'(d_hblank), 1);
        run_cen(31);
        check("h287.n_hsync", 32'(d_n_hsync), 1);
        run_cen(1);
        check("h288.n_hsync", 32'(d_n_hsync), 0);
        run_cen(31);
        check("h319.n_hsync", 32'(d_n_hsync), 0);
        run_cen(1);
        check("h320.hcnt", 32'(d_hcnt), 320);
        check("h320.n_hsync", 32'(d_n_hsync), 1);
        run_cen(63);
        check("h383.hcnt", 32'(d_hcnt), 383);
        check("h383.line_end", 32'(d_line_end), 1);
        check("h383.frame_end", 32'(d_frame_end), 0);
        run_cen(1);
        check("wrap.hcnt", 32'(d_hcnt), 0);
        check("wrap.vcnt", 32'(d_vcnt), 1);
        check("wrap.line_end", 32'(d_line_end), 0);

        // 50% duty cen: a line spans 768 clocks and line_end is held two clocks.
        apply(1'b1, 1'b0);
        ph = 1'b0;
        n = 0;
        while (d_vcnt !== 9'd1 && n < 2000) begin
            apply(ph, 1'b1);
            ph = ~ph;
            n++;
        end
        check("duty.reach_line1", 32'(d_vcnt), 1);
        cyc = 0;
        le = 0;
        while (d_vcnt === 9'd1 && cyc < 2000) begin
            apply(ph, 1'b1);
            ph = ~ph;
            cyc++;
            if (d_line_end === 1'b1) le++;
        end
        check("duty.line_cycles", cyc, 768);
        check("duty.line_end_cycles", le, 2);

        // Randomised enables, resets and flip requests against the model.
        for (int i = 0; i < 4000; i++) begin
            flip = ($urandom_range(0, 7) == 0) ? ~flip : flip;
            apply(($urandom_range(0, 3) != 0), ($urandom_range(0, 599) != 0));
        end
        flip = 1'b0;

        // Frame wrap on the small-timing instance.
        apply(1'b1, 1'b0);
        n = 0;
        while (s_frame_end !== 1'b1 && n < 200) begin
            apply(1'b1, 1'b1);
            n++;
        end
        check("sframe.hcnt", 32'(s_hcnt), 9);
        check("sframe.vcnt", 32'(s_vcnt), 5);
        check("sframe.vblank", 32'(s_vblank), 1);
        check("sframe.line_end", 32'(s_line_end), 1);
        apply(1'b1, 1'b1);
        check("sframe_wrap.hcnt", 32'(s_hcnt), 0);
        check("sframe_wrap.vcnt", 32'(s_vcnt), 0);
        check("sframe_wrap.vblank", 32'(s_vblank), 0);
        check("sframe_wrap.frame_end", 32'(s_frame_end), 0);

        // cen low holds everything.
        for (int i = 0; i < 5; i++) apply(1'b0, 1'b1);
        check("hold.d_hcnt", 32'(d_hcnt), 60);
        check("hold.s_hcnt", 32'(s_hcnt), 0);

`ifdef VIDEO_TIMING_FLIP_EN
        // Flip raised mid-frame waits for the frame wrap.
        apply(1'b1, 1'b0);
        run_cen(20);
        flip = 1'b1;
        run_cen(3);
        check("flip.raw_before_wrap", 32'(s_vcnt), 2);
        n = 0;
        while (s_frame_end !== 1'b1 && n < 200) begin
            apply(1'b1, 1'b1);
            n++;
        end
        run_cen(1);
        check("flip.h0", 32'(s_hcnt), 32'h0FF);
        run_cen(5);
        check("flip.h5", 32'(s_hcnt), 32'h0FA);
        run_cen(5);
        check("flip.v1", 32'(s_vcnt), 32'h0FE);
        check("flip.d_raw", 32'(d_vcnt), 0);
        flip = 1'b0;
`endif

        // Mid-operation reset with cen low.
        apply(1'b1, 1'b0);
        run_cen(50 * 384 + 100);
        check("mid.hcnt", 32'(d_hcnt), 100);
        check("mid.vcnt", 32'(d_vcnt), 50);
        check("mid.vblank", 32'(d_vblank), 0);
        apply(1'b0, 1'b0);
        check_reset_values("midreset");
        check("midreset.s_hcnt", 32'(s_hcnt), 0);

        apply(1'b0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
